// File: rtl/mult_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_pkg
// Brief    : Shared constants for the iterative multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package mult_div_pkg;

    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU  = 1'b1;

    localparam int MD_WIDTH     = 32;
    localparam int MD_CNT_WIDTH = $clog2(MD_WIDTH);

    typedef logic [1:0] md_state_t;

    localparam md_state_t ST_IDLE = 2'd0;
    localparam md_state_t ST_RUN  = 2'd1;
    localparam md_state_t ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Brief    : One combinational restoring-division step on {rem, quo}.
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_neg;

    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    // Since rem < divisor, shift < 2*divisor: a wrapped (negative) difference
    // always lands at or above 2^WIDTH, so the top bit is the borrow.
    assign w_neg   = w_diff[WIDTH];

    assign o_rem = w_neg ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], ~w_neg};

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative unsigned MULTU / DIVU with start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    md_state_t            r_state;
    logic                 r_op;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_opnd;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_dbz;

    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_quo;
    logic [2*WIDTH-1:0]   w_acc_next;

    // r_acc holds {partial product, multiplier} for MULTU and
    // {remainder, quotient} for DIVU; r_opnd is multiplicand or divisor.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    assign w_mul_next = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:1]};

    div_step #(
        .WIDTH     (WIDTH)
    ) u_div_step (
        .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
        .i_quo     (r_acc[WIDTH-1:0]),
        .i_divisor (r_opnd),
        .o_rem     (w_rem),
        .o_quo     (w_quo)
    );

    assign w_acc_next = (r_op == OP_MULTU) ? w_mul_next : {w_rem, w_quo};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= 1'b0;
            r_cnt   <= '0;
            r_opnd  <= '0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op   <= op;
                        r_cnt  <= '0;
                        r_dbz  <= 1'b0;
                        r_opnd <= (op == OP_MULTU) ? operand1 : operand2;
                        r_acc  <= {{WIDTH{1'b0}},
                                   (op == OP_MULTU) ? operand2 : operand1};
                        if (op == OP_DIVU && operand2 == '0) begin
                            r_hi    <= operand1;
                            r_lo    <= '1;
                            r_dbz   <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_hi    <= w_acc_next[2*WIDTH-1:WIDTH];
                        r_lo    <= w_acc_next[WIDTH-1:0];
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative unsigned multiply/divide unit in the execute stage. It takes the same `operand1`/`operand2` buses that feed the combinational ALU. Its 64-bit product, or its quotient and remainder, goes into HI/LO result registers that the writeback mux consumes. It replaces the single-cycle `*` and `/` paths with a 32-iteration shift-add multiplier and a restoring divider. It uses a start/busy/done handshake, so the control unit stalls the pipeline while `busy` is high.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.
- `clock`  in  1  single clock; everything updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  1  0 = MULTU, 1 = DIVU.
- `operand1`  in  WIDTH  multiplicand or dividend.
- `operand2`  in  WIDTH  multiplier or divisor.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; HI/LO valid from this cycle on.
- `hi`  out  WIDTH  product[63:32] or remainder.
- `lo`  out  WIDTH  product[31:0] or quotient.
- `div_by_zero`  out  1  set with `done` when DIVU had `operand2 == 0`; held until the next accept.

## Operation
- States: IDLE, RUN, DONE.
- **Reset**:
  - Forces IDLE.
  - `hi`, `lo`, the iteration counter and all internal registers clear to 0.
  - `busy`, `done` and `div_by_zero` clear to 0.
- **IDLE → accept**: the edge where `start=1` latches `op`, `operand1` and `operand2`, clears the counter, and clears `div_by_zero`.
  - DIVU with `operand2 == 0`: go straight to DONE with `lo=all-ones`, `hi=operand1`, `div_by_zero=1`.
  - Otherwise: go to RUN.
- **MULTU in RUN**: shift-add on a 2·WIDTH-bit accumulator.
  - Each edge: if multiplier LSB = 1, add the multiplicand into the upper half.
  - Then shift the {carry, accumulator} right by 1.
- **DIVU in RUN**: restoring division.
  - Each edge: shift {remainder, quotient} left by 1, then trial-subtract the divisor from the remainder.
  - If the result is non-negative (no borrow), keep it and set the quotient LSB to 1.
  - If it is negative, restore the remainder and set the quotient LSB to 0.
- **RUN exit**: after iteration WIDTH (counter == WIDTH−1 at that edge), the final results load into `hi`/`lo` and the state moves to DONE.
- **DONE**: `done=1` for exactly one cycle. The next edge returns to IDLE.
- **Start outside IDLE**: `start` in RUN or DONE is ignored. No queuing and no restart.
- **Result hold**: `hi`/`lo` change only on reset or on completion of an operation. They hold their value across IDLE and across accepts until the new result loads.
- **Arithmetic**: all arithmetic is unsigned. No overflow is possible because the 64-bit product is exact.
- **Reset mid-operation**: aborts on that edge. No `done` pulse follows, and outputs return to their reset values.

## Timing
- Accept edge = edge 0.
- Normal operation:
  - Iterations occur on edges 1…WIDTH.
  - `done` is high in the cycle after edge WIDTH (32 cycles after accept).
  - The state is back in IDLE after edge WIDTH+1.
  - The earliest next accept is edge WIDTH+2.
- Divide-by-zero: `done` is high in the cycle after edge 0, and the state returns to IDLE after edge 1.
- `busy` rises in the cycle after the accept edge and falls in the cycle after `done`.
- `busy` and `done` are registered state decodes, with no combinational path from `start`.

## Structure
- **Package `mult_div_pkg`**:
  - op encoding constants `OP_MULTU=1'b0`, `OP_DIVU=1'b1`;
  - state enum {IDLE, RUN, DONE};
  - `MD_WIDTH=32`;
  - counter width `$clog2(MD_WIDTH)`.
- **Optional sub-module `div_step`**: one combinational restoring-division step taking remainder, quotient and divisor in and returning the next remainder and quotient. It is isolated so it can be unit-tested.
- The FSM, counter and multiplier datapath stay in `mult_div_unit`.

## Test plan
- **Small multiply**: MULTU 7 × 6 → `done` 32 cycles after accept, `hi=0`, `lo=42`, `div_by_zero=0`.
- **Maximum multiply**: MULTU `0xFFFFFFFF × 0xFFFFFFFF` → `hi=0xFFFFFFFE`, `lo=0x00000001`.
- **Divide**:
  - DIVU 100 / 7 → `lo=14`, `hi=2`.
  - DIVU `0x80000000 / 1` → `lo=0x80000000`, `hi=0`.
- **Divide by zero**: DIVU 5 / 0 → `done` in the cycle after accept, `lo=0xFFFFFFFF`, `hi=5`, `div_by_zero=1`. A following MULTU 2 × 3 clears `div_by_zero` and gives `lo=6`.
- **Start while busy**: pulse `start` with new operands during RUN and during DONE → ignored; the results are those of the original operation and exactly one `done` pulse occurs.
- **Reset mid-operation**: assert `reset` at iteration 10 → next cycle IDLE, `busy=0`, `hi=lo=0`, no `done` pulse. A fresh MULTU 3 × 4 then completes with `lo=12`.
